// File: rtl/pam_demap_pack_if.sv
// AXI-stream word channel carrying packed PAM symbols toward the host FIFO.
interface pam_demap_pack_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0]   tdata;
   logic                    tvalid;
   logic                    tready;
   logic                    tlast;
   logic [DATA_WIDTH/8-1:0] tkeep;

   modport master (output tdata, output tvalid, output tlast, output tkeep, input tready);
   modport slave  (input tdata, input tvalid, input tlast, input tkeep, output tready);
endinterface

// File: rtl/pam_demap_pack.sv
// PAM slicer and MSB-first symbol packer feeding a small FWFT FIFO that
// drives a framed AXI-stream output. Inverse of the transmit serializer.
module pam_demap_pack #(
   parameter int AD_CVER_WIDTH = 12,
   parameter int PAM_ORDER     = 4,
   parameter int DATA_WIDTH    = 32,
   parameter int LENGTH_DATA   = 32,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                     clk,
   input  logic                     arst,
   input  logic [AD_CVER_WIDTH-1:0] ad_sample,
   input  logic                     sym_valid,
   input  logic                     sym_start,
   pam_demap_pack_if.master         m_axi,
   output logic                     frame_done,
   output logic                     overflow,
   output logic                     busy
);

   localparam int BPS = $clog2(PAM_ORDER);
   localparam int SPW = DATA_WIDTH / BPS;
   localparam int SCW = (SPW > 1) ? $clog2(SPW) : 1;
   localparam int WCW = (LENGTH_DATA > 1) ? $clog2(LENGTH_DATA) : 1;
   localparam int AW  = $clog2(FIFO_DEPTH);

   localparam logic [SCW-1:0] SYM_LAST  = SCW'(SPW - 1);
   localparam logic [WCW-1:0] WORD_LAST = WCW'(LENGTH_DATA - 1);
   localparam logic [AW:0]    FIFO_FULL = (AW+1)'(FIFO_DEPTH);

   typedef enum logic {IDLE, PACK} state_t;

   state_t state, next_state;

   // Threshold k of the equal-spaced slicer: k * 2^AD_CVER_WIDTH / PAM_ORDER.
   function automatic logic [AD_CVER_WIDTH:0] thr(input int unsigned k);
      thr = (AD_CVER_WIDTH+1)'(k << (AD_CVER_WIDTH - BPS));
   endfunction

   // ---------------- slicer ----------------
   logic [BPS-1:0] slice_sym;
   logic [BPS-1:0] sl_sym;
   logic           sl_valid;
   logic           sl_start;

   // Symbol is the number of thresholds the sample reaches.
   always_comb begin
      slice_sym = '0;
      for (int unsigned k = 1; k < PAM_ORDER; k++) begin
         if ({1'b0, ad_sample} >= thr(k))
            slice_sym = slice_sym + BPS'(1);
      end
   end

   // Slice stage: decision registered with its qualifiers.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         sl_sym   <= '0;
         sl_valid <= 1'b0;
         sl_start <= 1'b0;
      end else begin
         sl_sym   <= slice_sym;
         sl_valid <= sym_valid;
         sl_start <= sym_valid & sym_start;
      end
   end

   // ---------------- packer control ----------------
   logic [DATA_WIDTH-1:0] shift_reg;
   logic [SCW-1:0]        sym_cnt;
   logic [WCW-1:0]        word_cnt;
   logic [DATA_WIDTH-1:0] word_next;
   logic                  start_hit;
   logic                  shift_en;
   logic                  word_done;
   logic                  last_word;

   // Shift register is kept full width; its low bits always hold the
   // symbols of the word in progress, oldest highest.
   assign word_next = {shift_reg[DATA_WIDTH-BPS-1:0], sl_sym};

   // State register.
   always_ff @(posedge clk or posedge arst) begin
      if (arst)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Next-state logic and per-sample decode.
   always_comb begin
      next_state = state;
      start_hit  = sl_valid && sl_start;
      shift_en   = sl_valid && !sl_start && (state == PACK);
      word_done  = shift_en && (sym_cnt == SYM_LAST);
      last_word  = word_done && (word_cnt == WORD_LAST);
      case (state)
         IDLE: if (start_hit) next_state = PACK;
         PACK: if (last_word) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // FSM outputs.
   always_comb begin
      busy = (state == PACK);
   end

   // Symbol/word counters, shift register and frame_done pulse; a start
   // sample always (re)opens the frame as symbol 0 of word 0.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         shift_reg  <= '0;
         sym_cnt    <= '0;
         word_cnt   <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= last_word;
         if (start_hit) begin
            shift_reg <= DATA_WIDTH'(sl_sym);
            sym_cnt   <= SCW'(1);
            word_cnt  <= '0;
         end else if (shift_en) begin
            shift_reg <= word_next;
            if (word_done) begin
               sym_cnt  <= '0;
               word_cnt <= last_word ? '0 : word_cnt + WCW'(1);
            end else begin
               sym_cnt <= sym_cnt + SCW'(1);
            end
         end
      end
   end

   // ---------------- output FIFO ----------------
   logic [DATA_WIDTH:0] mem [FIFO_DEPTH];
   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic [AW:0]         count;
   logic                fifo_empty;
   logic                fifo_full;
   logic                pop;
   logic                push_ok;
   logic                drop;

   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == FIFO_FULL);
   assign pop        = !fifo_empty && m_axi.tready;
   // A pop on the same edge frees the slot, so a full FIFO can still accept.
   assign push_ok    = word_done && (!fifo_full || pop);
   assign drop       = word_done && fifo_full && !pop;

   // Storage write; contents are only visible through the empty gate.
   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr] <= {last_word, word_next};
   end

   // Pointers, occupancy and sticky overflow.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
         if (drop) overflow <= 1'b1;
      end
   end

   // First-word-fall-through head; all AXIS outputs read zero when empty.
   always_comb begin
      m_axi.tvalid = !fifo_empty;
      m_axi.tkeep  = fifo_empty ? '0 : '1;
      {m_axi.tlast, m_axi.tdata} = fifo_empty ? '0 : mem[rd_ptr];
   end

endmodule

// File: tb/tb_pam_demap_pack.sv
// Directed bench for pam_demap_pack: PAM4, 12-bit samples, 32-bit words,
// 32-word frames, 4-deep FIFO.
module tb_pam_demap_pack;

   logic        clk = 1'b0;
   logic        arst;
   logic [11:0] ad_sample;
   logic        sym_valid;
   logic        sym_start;
   logic        frame_done;
   logic        overflow;
   logic        busy;

   int checks = 0;
   int errors = 0;

   logic [32:0] rxq [$];
   int          fd_cnt   = 0;
   int          keep_bad = 0;
   int          base;
   int          fd_base;
   int          kb_base;

   logic [11:0] pat1 [4];
   logic [11:0] pat2 [4];

   always #5 clk = ~clk;

   pam_demap_pack_if #(.DATA_WIDTH(32)) m_axi ();

   pam_demap_pack #(
      .AD_CVER_WIDTH(12),
      .PAM_ORDER    (4),
      .DATA_WIDTH   (32),
      .LENGTH_DATA  (32),
      .FIFO_DEPTH   (4)
   ) dut (
      .clk       (clk),
      .arst      (arst),
      .ad_sample (ad_sample),
      .sym_valid (sym_valid),
      .sym_start (sym_start),
      .m_axi     (m_axi),
      .frame_done(frame_done),
      .overflow  (overflow),
      .busy      (busy)
   );

   // Record every AXIS handshake and every frame_done cycle.
   always @(posedge clk) begin
      if (m_axi.tvalid && m_axi.tready) begin
         rxq.push_back({m_axi.tlast, m_axi.tdata});
         if (m_axi.tkeep !== 4'hF) keep_bad++;
      end
      if (frame_done) fd_cnt++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [32:0] rx(input int i);
      if (i < rxq.size()) return rxq[i];
      return 33'bx;
   endfunction

   function automatic logic [11:0] lvl(input int v);
      return 12'(v * 1024 + 512);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [11:0] s, input logic st);
      ad_sample = s;
      sym_valid = 1'b1;
      sym_start = st;
      tick();
      sym_valid = 1'b0;
      sym_start = 1'b0;
   endtask

   // Idle cycle with a stray start that must be ignored (not valid).
   task automatic gap();
      sym_valid = 1'b0;
      sym_start = 1'b1;
      tick();
      sym_start = 1'b0;
   endtask

   task automatic mark();
      base    = rxq.size();
      fd_base = fd_cnt;
      kb_base = keep_bad;
   endtask

   initial begin
      pat1 = '{12'h3FF, 12'h400, 12'h800, 12'hC00};
      pat2 = '{12'h7FF, 12'hBFF, 12'hFFF, 12'h000};
      arst         = 1'b1;
      ad_sample    = '0;
      sym_valid    = 1'b0;
      sym_start    = 1'b0;
      m_axi.tready = 1'b1;

      // ---- reset state ----
      #12;
      chk("rst_tvalid", m_axi.tvalid, 0);
      chk("rst_tlast", m_axi.tlast, 0);
      chk("rst_tdata", m_axi.tdata, 0);
      chk("rst_tkeep", m_axi.tkeep, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_busy", busy, 0);
      arst = 1'b0;
      tick();

      // ---- full frame, slicer boundaries 0x3FF/0x400/0x800/0xC00 ----
      mark();
      for (int i = 0; i < 512; i++) begin
         send(pat1[i % 4], i == 0);
         if (i == 0)   chk("busy_before_rise", busy, 0);
         if (i == 1)   chk("busy_rise", busy, 1);
         if (i == 15)  chk("latency_not_yet", m_axi.tvalid, 0);
         if (i == 16)  chk("latency_tvalid", m_axi.tvalid, 1);
         if (i == 511) begin
            chk("fd_before", frame_done, 0);
            chk("busy_before_end", busy, 1);
         end
      end
      tick();
      chk("fd_pulse", frame_done, 1);
      chk("busy_fall", busy, 0);
      tick();
      chk("fd_one_cycle", frame_done, 0);
      tick();
      tick();
      chk("full_count", rxq.size() - base, 32);
      for (int i = 0; i < 32; i++)
         chk($sformatf("full_w%0d", i), rx(base + i), {(i == 31), 32'h1B1B1B1B});
      chk("full_fd_cnt", fd_cnt - fd_base, 1);
      chk("full_tkeep", keep_bad - kb_base, 0);

      // ---- backpressure: FIFO keeps words 0-3, rest dropped ----
      mark();
      m_axi.tready = 1'b0;
      for (int i = 0; i < 512; i++) begin
         send(lvl(((i / 16) + 1) % 4), i == 0);
         if (i == 79) chk("ovf_before_w4", overflow, 0);
         if (i == 80) chk("ovf_after_w4", overflow, 1);
      end
      tick();
      tick();
      chk("bp_fd_cnt", fd_cnt - fd_base, 1);
      chk("bp_busy", busy, 0);
      chk("bp_tvalid_held", m_axi.tvalid, 1);
      chk("bp_tdata_held", m_axi.tdata, 32'h55555555);
      chk("bp_tlast_held", m_axi.tlast, 0);
      chk("bp_no_pop", rxq.size() - base, 0);
      m_axi.tready = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      chk("bp_count", rxq.size() - base, 4);
      chk("bp_w0", rx(base + 0), {1'b0, 32'h55555555});
      chk("bp_w1", rx(base + 1), {1'b0, 32'hAAAAAAAA});
      chk("bp_w2", rx(base + 2), {1'b0, 32'hFFFFFFFF});
      chk("bp_w3", rx(base + 3), {1'b0, 32'h00000000});
      chk("bp_drained", m_axi.tvalid, 0);
      chk("bp_ovf_sticky", overflow, 1);

      // ---- restart at symbol 7 of word 3 ----
      mark();
      for (int i = 0; i < 55; i++) send(lvl(1), i == 0);
      for (int j = 0; j < 512; j++) send(lvl((j == 0) ? 3 : 2), j == 0);
      for (int i = 0; i < 4; i++) tick();
      chk("rs_count", rxq.size() - base, 35);
      for (int i = 0; i < 35; i++)
         chk($sformatf("rs_w%0d", i), rx(base + i),
             (i < 3)  ? {1'b0, 32'h55555555} :
             (i == 3) ? {1'b0, 32'hEAAAAAAA} : {(i == 34), 32'hAAAAAAAA});
      chk("rs_fd_cnt", fd_cnt - fd_base, 1);

      // ---- reset mid-frame ----
      mark();
      m_axi.tready = 1'b0;
      for (int i = 0; i < 160; i++) send(lvl(2), i == 0);
      chk("mr_tvalid_pre", m_axi.tvalid, 1);
      arst = 1'b1;
      #1;
      chk("mr_tvalid", m_axi.tvalid, 0);
      chk("mr_tlast", m_axi.tlast, 0);
      chk("mr_tdata", m_axi.tdata, 0);
      chk("mr_tkeep", m_axi.tkeep, 0);
      chk("mr_frame_done", frame_done, 0);
      chk("mr_overflow", overflow, 0);
      chk("mr_busy", busy, 0);
      #2;
      arst = 1'b0;
      m_axi.tready = 1'b1;
      for (int i = 0; i < 40; i++) send(lvl(1), 1'b0);
      for (int i = 0; i < 4; i++) tick();
      chk("mr_no_stale", rxq.size() - base, 0);
      chk("mr_tvalid_post", m_axi.tvalid, 0);
      chk("mr_busy_post", busy, 0);
      chk("mr_fd_cnt", fd_cnt - fd_base, 0);

      // ---- idle gaps, boundaries 0x7FF/0xBFF/0xFFF/0x000 ----
      mark();
      for (int i = 0; i < 5; i++) send(12'hFFF, 1'b0);
      for (int i = 0; i < 512; i++) begin
         send(pat2[i % 4], i == 0);
         gap();
      end
      for (int i = 0; i < 4; i++) tick();
      chk("gap_count", rxq.size() - base, 32);
      for (int i = 0; i < 32; i++)
         chk($sformatf("gap_w%0d", i), rx(base + i), {(i == 31), 32'h6C6C6C6C});
      chk("gap_fd_cnt", fd_cnt - fd_base, 1);
      chk("gap_tkeep", keep_bad - kb_base, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pam_demap_pack.md
# pam_demap_pack

PAM slicer and symbol packer on the receive side of the VLC link. It takes synchronised, symbol-rate ADC samples and hard-decides each sample to a PAM level using fixed equal-spaced thresholds. It packs the decided symbols MSB-first into DATA_WIDTH-bit words and delivers them as framed AXI-stream toward the host FIFO. It is the inverse of the transmit-side word-to-PAM-symbol serializer: frame length, symbol order and level mapping mirror that path exactly.

## Interface
- AD_CVER_WIDTH, 12, ADC sample width, unsigned.
- PAM_ORDER, 4, PAM order; 2, 4 or 8 supported; BPS = log2(PAM_ORDER) bits per symbol.
- DATA_WIDTH, 32, AXIS word width; must be a multiple of BPS; SPW = DATA_WIDTH/BPS symbols per word.
- LENGTH_DATA, 32, words per frame.
- FIFO_DEPTH, 4, output FIFO depth; power of 2.
- clk  input  1  single clock, all logic rising-edge.
- arst  input  1  asynchronous, active-high reset.
- ad_sample  input  AD_CVER_WIDTH  symbol-centre sample from the synchroniser.
- sym_valid  input  1  ad_sample is valid this cycle.
- sym_start  input  1  qualified by sym_valid; this sample is symbol 0 of a frame payload.
- m_axi_tdata  output  DATA_WIDTH  packed word.
- m_axi_tvalid  output  1  word available.
- m_axi_tready  input  1  downstream accept.
- m_axi_tlast  output  1  last word of frame.
- m_axi_tkeep  output  DATA_WIDTH/8  all ones whenever tvalid = 1, else zero.
- frame_done  output  1  one-cycle pulse when the frame's final word is packed.
- overflow  output  1  sticky; a completed word found the FIFO full.
- busy  output  1  high in PACK state.

## Operation
- Slicer:
  - Threshold T_k = k * 2^AD_CVER_WIDTH / PAM_ORDER, for k = 1..PAM_ORDER-1.
  - Symbol = number of k with ad_sample >= T_k.
  - Natural binary mapping; level 0 is the lowest amplitude.
  - The slice result is registered together with its valid and start flags (slice stage).
- FSM states: IDLE and PACK.
  - IDLE -> PACK when the slice stage holds a sample with start set. That symbol becomes symbol 0 of word 0.
  - In IDLE, sliced samples without start are discarded.
  - In PACK, every sliced sample shifts into the packer. The first symbol lands in bits [DATA_WIDTH-1 -: BPS].
  - After SPW symbols the word is complete. The completed word is {shift_reg, new_sym}, pushed to the FIFO on the same edge.
  - The word counter increments on every completed word, whether pushed or dropped.
  - Word LENGTH_DATA-1 is pushed with tlast = 1. On that same edge frame_done pulses and the FSM returns to IDLE.
  - A start flag while in PACK restarts the frame: the partial word is discarded, symbol and word counters reset, and that symbol becomes symbol 0. Words already in the FIFO are kept and carry no tlast.
- FIFO:
  - First-word-fall-through; stores {tlast, tdata}.
  - tvalid = not empty.
  - Pop on tvalid && tready.
  - A push onto a full FIFO drops the word and sets overflow. The word counter still advances. If the dropped word is the last one, the frame still ends.
  - Simultaneous push and pop while full is allowed: the pop frees the slot and nothing is dropped.
- Reset clears:
  - FSM to IDLE.
  - Counters and shift register.
  - FIFO to empty.
  - All outputs to 0: tvalid, tlast, tdata, tkeep, frame_done, overflow, busy.
- Reset mid-frame discards all buffered data. No partial word is ever emitted.

## Timing
- Accept rate: one symbol per cycle sustained; there is no input backpressure.
- Latency: if the last symbol of a word is sampled at edge E, the word is in the FIFO after edge E+1. With an empty FIFO, m_axi_tvalid is high in the cycle following E+1.
- frame_done is high for exactly the cycle following the edge that pushes the last word.
- busy rises the cycle after the start sample is sliced. It falls together with the frame_done pulse.
- AXIS: tdata, tlast and tkeep are held stable while tvalid && !tready. tvalid never drops without a handshake.

## Test plan
- Slicer boundaries (PAM4, 12-bit):
  - 0x3FF -> 0, 0x400 -> 1, 0x7FF -> 1, 0x800 -> 2, 0xBFF -> 2, 0xC00 -> 3, 0xFFF -> 3.
  - Checked through a packed word: samples 0x3FF, 0x400, 0x800, 0xC00 repeated with sym_start on the first sample, tready = 1 -> tdata = 0x1B1B1B1B.
- Full frame:
  - 512 continuous symbols after start, tready = 1 -> 32 words.
  - tlast only on word 32; frame_done pulses once; busy falls; tkeep = 0xF on all words.
  - Latency: tvalid rises 2 edges after the 16th symbol is sampled.
- Backpressure:
  - tready = 0 for a whole frame -> FIFO holds words 0-3.
  - overflow = 1 after word 4 completes; words 4-31 are lost.
  - Releasing tready yields exactly 4 words with tlast = 0.
- Restart: sym_start reasserted at symbol 7 of word 3 -> words 0-2 emitted without tlast; the new frame begins with the restarting sample as symbol 0.
- Reset mid-frame: arst pulsed after 10 words with tready = 0 -> tvalid = 0 and all outputs 0 immediately; no stale word appears afterwards.
- Idle gaps: sym_valid toggling 1/0 within a frame -> identical tdata to the continuous case; samples before sym_start are ignored.
